// File: rtl/usb_remote_wakeup.sv
// usb_remote_wakeup: device-side USB full-speed suspend detector and remote-wakeup K driver.
// Optional build macro USB_RESUME_FILTER_EN: host K must persist 3 ticks before resume is accepted.
module usb_remote_wakeup #(
    parameter int IN_CLK_MHZ  = 12,
    parameter int SUSPEND_US  = 3000,
    parameter int MIN_IDLE_US = 5000,
    parameter int K_DRIVE_US  = 10000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic usb_p_rx,
    input  logic usb_n_rx,
    input  logic bus_reset,
    input  logic wakeup_enabled,
    input  logic wakeup_req,
    output logic usb_tx_en,
    output logic usb_p_tx,
    output logic usb_n_tx,
    output logic suspended,
    output logic resume_pulse,
    output logic wakeup_busy
);
    // state      | meaning
    // ACTIVE     | bus in use, timing continuous idle J
    // SUSPENDED  | bus suspended, firmware wakeup may be pended
    // DRIVE_K    | driving remote-wakeup K onto the bus
    // RESUMING   | waiting for host end-of-resume SE0, then J
    typedef enum logic [1:0] {ACTIVE, SUSPENDED, DRIVE_K, RESUMING} state_t;

    localparam int              PW           = (IN_CLK_MHZ > 1) ? $clog2(IN_CLK_MHZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX    = PW'(IN_CLK_MHZ - 1);
    localparam logic [15:0]     SUSPEND_CNT  = 16'(SUSPEND_US);
    localparam logic [15:0]     MIN_IDLE_CNT = 16'(MIN_IDLE_US);
    localparam logic [15:0]     K_DRIVE_CNT  = 16'(K_DRIVE_US);

    state_t        state;
    logic [1:0]    p_sync;
    logic [1:0]    n_sync;
    logic [PW-1:0] presc;
    logic          tick;
    logic          line_j;
    logic          line_k;
    logic          line_se0;
    logic          host_k;
    logic [15:0]   idle_us;
    logic [15:0]   k_us;
    logic          wake_pend;
    logic          seen_se0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_sync <= '0;
            n_sync <= '0;
            presc  <= '0;
        end else begin
            p_sync <= {p_sync[0], usb_p_rx};
            n_sync <= {n_sync[0], usb_n_rx};
            presc  <= tick ? '0 : presc + 1'b1;
        end
    end

    assign tick     = (presc == PRESC_MAX);
    assign line_j   =  p_sync[1] & ~n_sync[1];
    assign line_k   = ~p_sync[1] &  n_sync[1];
    assign line_se0 = ~p_sync[1] & ~n_sync[1];

`ifdef USB_RESUME_FILTER_EN
    // Counts ticks of uninterrupted K while suspended; resume fires on the third.
    logic [1:0] k_ticks;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_ticks <= '0;
        end else if (!line_k || state != SUSPENDED) begin
            k_ticks <= '0;
        end else if (tick && k_ticks != 2'd3) begin
            k_ticks <= k_ticks + 2'd1;
        end
    end

    assign host_k = line_k & tick & (k_ticks == 2'd2);
`else
    assign host_k = line_k;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ACTIVE;
            idle_us      <= '0;
            k_us         <= '0;
            wake_pend    <= 1'b0;
            seen_se0     <= 1'b0;
            usb_tx_en    <= 1'b0;
            usb_p_tx     <= 1'b0;
            usb_n_tx     <= 1'b0;
            suspended    <= 1'b0;
            resume_pulse <= 1'b0;
            wakeup_busy  <= 1'b0;
        end else begin
            resume_pulse <= 1'b0;
            if (!line_j) begin
                idle_us <= '0;
            end else if (tick && idle_us != 16'hFFFF) begin
                idle_us <= idle_us + 16'd1;
            end

            if (bus_reset) begin
                state       <= ACTIVE;
                idle_us     <= '0;
                k_us        <= '0;
                wake_pend   <= 1'b0;
                seen_se0    <= 1'b0;
                usb_tx_en   <= 1'b0;
                usb_p_tx    <= 1'b0;
                usb_n_tx    <= 1'b0;
                suspended   <= 1'b0;
                wakeup_busy <= 1'b0;
            end else begin
                case (state)
                    ACTIVE: begin
                        if (idle_us >= SUSPEND_CNT) begin
                            state     <= SUSPENDED;
                            suspended <= 1'b1;
                        end
                    end
                    SUSPENDED: begin
                        if (wakeup_req && wakeup_enabled) begin
                            wake_pend <= 1'b1;
                        end
                        // Host resume wins over starting our own K drive.
                        if (host_k) begin
                            state     <= RESUMING;
                            wake_pend <= 1'b0;
                            seen_se0  <= 1'b0;
                        end else if (wake_pend && idle_us >= MIN_IDLE_CNT) begin
                            state       <= DRIVE_K;
                            wake_pend   <= 1'b0;
                            k_us        <= '0;
                            usb_tx_en   <= 1'b1;
                            usb_p_tx    <= 1'b0;
                            usb_n_tx    <= 1'b1;
                            wakeup_busy <= 1'b1;
                        end
                    end
                    DRIVE_K: begin
                        if (k_us == K_DRIVE_CNT) begin
                            state       <= RESUMING;
                            seen_se0    <= 1'b0;
                            usb_tx_en   <= 1'b0;
                            usb_p_tx    <= 1'b0;
                            usb_n_tx    <= 1'b0;
                            wakeup_busy <= 1'b0;
                        end else if (tick) begin
                            k_us <= k_us + 16'd1;
                        end
                    end
                    RESUMING: begin
                        if (line_se0) begin
                            seen_se0 <= 1'b1;
                        end else if (seen_se0 && line_j) begin
                            state        <= ACTIVE;
                            seen_se0     <= 1'b0;
                            idle_us      <= '0;
                            suspended    <= 1'b0;
                            resume_pulse <= 1'b1;
                        end
                    end
                    default: state <= ACTIVE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_remote_wakeup.sv
// Directed bench for usb_remote_wakeup with shortened timing parameters.
`timescale 1ns/1ps
module tb_usb_remote_wakeup;
    localparam int US       = 12;
    localparam int SUSP     = 300;
    localparam int MIN_IDLE = 500;
    localparam int KDRV     = 1000;

    logic clk            = 1'b0;
    logic reset_n        = 1'b0;
    logic usb_p_rx       = 1'b1;
    logic usb_n_rx       = 1'b0;
    logic bus_reset      = 1'b0;
    logic wakeup_enabled = 1'b0;
    logic wakeup_req     = 1'b0;
    logic usb_tx_en, usb_p_tx, usb_n_tx, suspended, resume_pulse, wakeup_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_remote_wakeup #(
        .IN_CLK_MHZ (US),
        .SUSPEND_US (SUSP),
        .MIN_IDLE_US(MIN_IDLE),
        .K_DRIVE_US (KDRV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .usb_p_rx      (usb_p_rx),
        .usb_n_rx      (usb_n_rx),
        .bus_reset     (bus_reset),
        .wakeup_enabled(wakeup_enabled),
        .wakeup_req    (wakeup_req),
        .usb_tx_en     (usb_tx_en),
        .usb_p_tx      (usb_p_tx),
        .usb_n_tx      (usb_n_tx),
        .suspended     (suspended),
        .resume_pulse  (resume_pulse),
        .wakeup_busy   (wakeup_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input logic p, input logic n);
        usb_p_rx = p;
        usb_n_rx = n;
    endtask

    task automatic pulse_req();
        wakeup_req = 1'b1;
        step(1);
        wakeup_req = 1'b0;
    endtask

    task automatic wait_susp(output int cnt, input int bound);
        cnt = 0;
        while (!suspended && cnt < bound) begin
            step(1);
            cnt++;
        end
    endtask

    task automatic wait_tx(input logic level, output int cnt, input int bound);
        cnt = 0;
        while (usb_tx_en !== level && cnt < bound) begin
            step(1);
            cnt++;
        end
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (resume_pulse) pulses++;
        end
    endtask

    task automatic host_eop_j(output int pulses);
        set_line(1'b0, 1'b0);
        step(2);
        set_line(1'b1, 1'b0);
        count_pulses(50, pulses);
    endtask

    function automatic logic [5:0] outs();
        return {usb_tx_en, usb_p_tx, usb_n_tx, suspended, resume_pulse, wakeup_busy};
    endfunction

    initial begin
        int cnt;
        int pulses;
        int bad;

        // reset and first suspend from continuous J
        step(3);
        check_val("reset_outs", outs(), 6'b0);
        reset_n = 1'b1;
        wait_susp(cnt, SUSP * US + 200);
        check_val("susp_time", (cnt >= SUSP * US - US) && (cnt <= SUSP * US + US + 2), 1);
        check_val("susp_outs", outs(), 6'b000100);

        // async reset while suspended clears outputs without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_outs", outs(), 6'b0);
        step(2);
        reset_n = 1'b1;

        // single K sample just before the threshold restarts the idle count
        step(SUSP * US - US);
        set_line(1'b0, 1'b1);
        step(1);
        set_line(1'b1, 1'b0);
        step(40);
        check_val("glitch_no_susp", suspended, 0);
        wait_susp(cnt, SUSP * US + 200);
        check_val("glitch_resusp", (cnt >= SUSP * US - 60) && (cnt <= SUSP * US), 1);

        // remote wakeup: request at idle ~350 us, K driven once idle reaches MIN_IDLE
        wakeup_enabled = 1'b1;
        step(50 * US - 1);
        pulse_req();
        wait_tx(1'b1, cnt, (MIN_IDLE - 300) * US);
        check_val("drive_start", (cnt >= (MIN_IDLE - 350) * US - 2 * US) &&
                                 (cnt <= (MIN_IDLE - 350) * US + 2 * US), 1);
        check_val("drive_outs", outs(), 6'b101101);
        set_line(1'b0, 1'b1);
        cnt = 0;
        bad = 0;
        while (usb_tx_en && cnt < KDRV * US + 100) begin
            if (outs() !== 6'b101101) bad++;
            step(1);
            cnt++;
        end
        check_val("drive_hold", bad, 0);
        check_val("drive_len", (cnt >= KDRV * US - US) && (cnt <= KDRV * US + US + 2), 1);
        check_val("resuming_outs", outs(), 6'b000100);

        // host continues K, then EOP and J
        count_pulses(50 * US, pulses);
        check_val("no_pulse_in_k", pulses, 0);
        host_eop_j(pulses);
        check_val("resume_pulse_once", pulses, 1);
        check_val("active_after_resume", suspended, 0);

        // disabled wakeup is dropped; short host K resumes
        wait_susp(cnt, SUSP * US + 200);
        check_val("susp_again", suspended, 1);
        wakeup_enabled = 1'b0;
        pulse_req();
        bad = 0;
        for (int i = 0; i < (MIN_IDLE - SUSP + 50) * US; i++) begin
            step(1);
            if (usb_tx_en) bad++;
        end
        check_val("disabled_no_drive", bad, 0);
        set_line(1'b0, 1'b1);
        step(US);
        set_line(1'b1, 1'b0);
        step(5 * US);
        check_val("short_k_susp", suspended, 1);
        host_eop_j(pulses);
`ifdef USB_RESUME_FILTER_EN
        check_val("filtered_glitch_pulse", pulses, 0);
        check_val("filtered_glitch_susp", suspended, 1);
        set_line(1'b0, 1'b1);
        step(5 * US);
        host_eop_j(pulses);
`endif
        check_val("host_resume_pulse", pulses, 1);
        check_val("host_resume_active", suspended, 0);

        // bus reset in the middle of the K drive
        wait_susp(cnt, SUSP * US + 200);
        wakeup_enabled = 1'b1;
        pulse_req();
        wait_tx(1'b1, cnt, (MIN_IDLE - SUSP + 20) * US);
        check_val("drive2_start", usb_tx_en, 1);
        set_line(1'b0, 1'b1);
        step(400 * US);
        check_val("drive2_mid", usb_tx_en, 1);
        bus_reset = 1'b1;
        step(1);
        check_val("bus_reset_outs", outs(), 6'b0);
        count_pulses(50, pulses);
        check_val("bus_reset_no_pulse", pulses, 0);
        bus_reset = 1'b0;
        set_line(1'b1, 1'b0);
        step(100);
        check_val("after_bus_reset_active", suspended, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
